// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder.
package imem_fetch_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_LOAD = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response channel between the PC/fetch initiator and the responder.
interface imem_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_fetch_responder_ram.sv
// Simple dual-port synchronous instruction RAM, one-cycle read latency, no reset.
module imem_fetch_responder_ram #(
   parameter int DEPTH = 16384,
   parameter int AW    = 14
) (
   input  logic          clock_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clock_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-side responder: owns the instruction RAM, serves one-cycle fetches,
// and accepts program-load writes while in load mode.
module imem_fetch_responder
   import imem_fetch_responder_pkg::*;
#(
   parameter int          DEPTH     = 16384,
   parameter int          AW        = 14,
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic                    clock_i,
   input  logic                    reset_ni,
   imem_fetch_responder_if.slave   bus,
   input  logic                    prog_mode_i,
   input  logic                    ld_we_i,
   input  logic [AW-1:0]           ld_addr_i,
   input  logic [31:0]             ld_data_i,
   output logic [31:0]             ld_count_o,
   output logic [31:0]             fetch_count_o
);

   state_e      state_q;
   logic        rsp_valid_q, rsp_err_q, fresh_q;
   logic [31:0] rsp_addr_q, instr_q, ld_cnt_q, fetch_cnt_q;

   logic        req_hs, rsp_hs, req_err, ram_re, ram_we;
   logic [31:0] offset, ram_rdata;

   assign bus.req_ready = !prog_mode_i && (state_q != S_LOAD) && (!rsp_valid_q || bus.rsp_ready);
   assign req_hs        = bus.req_valid && bus.req_ready;
   assign rsp_hs        = rsp_valid_q && bus.rsp_ready;

   // DEPTH is a power of two, so range check reduces to the bits above the word index.
   assign offset  = bus.req_addr - BASE_ADDR;
   assign req_err = (offset[1:0] != 2'b00) || (offset[31:AW+2] != '0);
   assign ram_re  = req_hs && !req_err;
   assign ram_we  = (state_q == S_LOAD) && prog_mode_i && ld_we_i;

   imem_fetch_responder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clock_i (clock_i),
      .we_i    (ram_we),
      .waddr_i (ld_addr_i),
      .wdata_i (ld_data_i),
      .re_i    (ram_re),
      .raddr_i (offset[AW+1:2]),
      .rdata_o (ram_rdata)
   );

   // RAM output is live only the cycle after a read; afterwards the captured copy is shown.
   assign bus.rsp_instr = rsp_err_q ? NOP_INSTR : (fresh_q ? ram_rdata : instr_q);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_addr  = rsp_addr_q;
   assign bus.rsp_err   = rsp_err_q;
   assign ld_count_o    = ld_cnt_q;
   assign fetch_count_o = fetch_cnt_q;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_addr_q  <= '0;
         instr_q     <= '0;
         fresh_q     <= 1'b0;
         ld_cnt_q    <= '0;
         fetch_cnt_q <= '0;
      end else begin
         if (fresh_q) instr_q <= ram_rdata;
         fresh_q <= ram_re;
         if (req_hs) begin
            rsp_addr_q  <= bus.req_addr;
            rsp_err_q   <= req_err;
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (ram_we) ld_cnt_q <= ld_cnt_q + 32'd1;
         case (state_q)
            S_IDLE: begin
               if (req_hs) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
               end else if (prog_mode_i) begin
                  state_q <= S_LOAD;
               end
            end
            S_RESP: begin
               if (rsp_hs && !req_hs) begin
                  state_q     <= prog_mode_i ? S_LOAD : S_IDLE;
                  rsp_valid_q <= 1'b0;
               end
            end
            S_LOAD: begin
               if (!prog_mode_i) state_q <= S_IDLE;
            end
            default: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: load, fetch, backpressure, errors, reset, wrap.
module tb_imem_fetch_responder;
   localparam int          DEPTH = 16384;
   localparam int          AW    = 14;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          prog_mode = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [31:0]   ld_data = '0;
   logic [31:0]   ld_count, fetch_count;

   imem_fetch_responder_if bus ();

   imem_fetch_responder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(BASE), .NOP_INSTR(NOP)) dut (
      .clock_i       (clk),
      .reset_ni      (rst_n),
      .bus           (bus.slave),
      .prog_mode_i   (prog_mode),
      .ld_we_i       (ld_we),
      .ld_addr_i     (ld_addr),
      .ld_data_i     (ld_data),
      .ld_count_o    (ld_count),
      .fetch_count_o (fetch_count)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   exp_t        sb[$];
   logic [31:0] model [int];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic exp_t predict(input logic [31:0] a);
      exp_t        e;
      logic [31:0] off;
      logic [29:0] word;
      off     = a - BASE;
      word    = off[31:2];
      e.addr  = a;
      e.err   = (off[1:0] != 2'b00) || (int'(word) >= DEPTH) || (word[29:28] != 2'b00);
      e.instr = e.err ? NOP : model[int'(word)];
      return e;
   endfunction

   // Sample mid-cycle: pop on response handshake, push on request handshake.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_addr", bus.rsp_addr, e.addr);
            chk("rsp_instr", bus.rsp_instr, e.instr);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
         end
      end
      if (rst_n && bus.req_valid && bus.req_ready) sb.push_back(predict(bus.req_addr));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = a; ld_data = d;
      model[int'(a)] = d;
      step();
      ld_we = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      bus.req_valid = 1'b1; bus.req_addr = a;
      step();
      bus.req_valid = 1'b0;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      #12;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_instr", bus.rsp_instr, 32'd0);
      chk("rst_rsp_addr", bus.rsp_addr, 32'd0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_ld_count", ld_count, 32'd0);
      chk("rst_fetch_count", fetch_count, 32'd0);
      rst_n = 1'b1;
      step();

      // Program load
      prog_mode = 1'b1;
      step();
      load_word(0, 32'h11);
      load_word(1, 32'h22);
      load_word(2, 32'h33);
      load_word(3, 32'h44);
      prog_mode = 1'b0;
      step();
      chk("ld_count_4", ld_count, 32'd4);

      // Back-to-back fetches
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'b1; bus.req_addr = 32'(i * 4);
         step();
      end
      bus.req_valid = 1'b0;
      step();
      chk("fetch_count_4", fetch_count, 32'd4);

      // Backpressure
      bus.rsp_ready = 1'b0;
      fetch(32'd4);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_instr", bus.rsp_instr, 32'h22);
         chk("bp_addr", bus.rsp_addr, 32'd4);
         chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
      step();
      chk("bp_drained", 32'(bus.rsp_valid), 32'd0);

      // Error responses
      fetch(32'h2);
      fetch(32'(DEPTH * 4));
      step();
      chk("fetch_count_err", fetch_count, 32'd7);

      // prog_mode raised while a response is pending
      bus.rsp_ready = 1'b0;
      fetch(32'd8);
      prog_mode = 1'b1; ld_we = 1'b1; ld_addr = 2; ld_data = 32'hDEAD_BEEF;
      #1;
      chk("pm_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      step();
      ld_we = 1'b0;
      chk("pm_ld_count_hold", ld_count, 32'd4);
      chk("pm_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("pm_rsp_instr", bus.rsp_instr, 32'h33);
      bus.rsp_ready = 1'b1;
      step();
      load_word(5, 32'h55);
      chk("pm_ld_count_5", ld_count, 32'd5);
      prog_mode = 1'b0;
      step();
      fetch(32'd20);
      fetch(32'd8);
      step();

      // Async reset in the middle of a response
      bus.rsp_ready = 1'b0;
      fetch(32'd12);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("ar_ld_count", ld_count, 32'd0);
      chk("ar_fetch_count", fetch_count, 32'd0);
      #3;
      rst_n = 1'b1;
      step();
      bus.rsp_ready = 1'b1;
      fetch(32'd12);
      step();

      // Counter wrap
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      chk("wrap_preload", fetch_count, 32'hFFFF_FFFF);
      fetch(32'd0);
      chk("wrap_zero", fetch_count, 32'd0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end
endmodule
